// File: rtl/brent_kung_adder_pipe.sv
// brent_kung_adder_pipe
// Pipelined adder/subtractor that processes one CHUNK-bit slice per stage.
// Each stage runs a CHUNK-bit Brent-Kung prefix network on its slice and
// registers the carry for the next stage. Unprocessed operand slices travel
// forward with the beat, and finished result slices are carried along too.
// The whole pipe advances together, or stalls together, under one enable.
// WIDTH must be a multiple of CHUNK. CHUNK must be a power of two >= 2.
module brent_kung_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int STAGES = WIDTH / CHUNK;

  // Advance when the output slot is empty or is being drained this cycle.
  logic adv;
  assign adv     = ~valid_o | ready_i;
  assign ready_o = adv;

  // Brent-Kung slice adder. Result is {carry_out, sum}.
  // Carry-in is folded into generate bit 0 so the prefix tree yields every
  // carry directly. The up-sweep builds power-of-two spans, and the
  // down-sweep fills in the remaining positions.
  function automatic logic [CHUNK:0] bk_add(input logic [CHUNK-1:0] a,
                                            input logic [CHUNK-1:0] b,
                                            input logic             cin);
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] gp;
    logic [CHUNK-1:0] pp;
    logic [CHUNK:0]   c;
    p     = a ^ b;
    gp    = a & b;
    gp[0] = gp[0] | (p[0] & cin);
    pp    = p;
    for (int d = 1; d < CHUNK; d = d * 2) begin
      for (int i = 2 * d - 1; i < CHUNK; i = i + 2 * d) begin
        gp[i] = gp[i] | (pp[i] & gp[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    for (int d = CHUNK / 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < CHUNK; i = i + 2 * d) begin
        gp[i] = gp[i] | (pp[i] & gp[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    c[0]       = cin;
    c[CHUNK:1] = gp;
    return {c[CHUNK], p ^ c[CHUNK-1:0]};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added by this stage and all later stages.
    localparam int IW = WIDTH - k * CHUNK;

    logic [IW-1:0]          a_s;
    logic [IW-1:0]          b_s;
    logic                   c_s;
    logic                   v_s;
    logic [CHUNK:0]         res;
    logic [(k+1)*CHUNK-1:0] sum_nx;
    logic [(k+1)*CHUNK-1:0] sum_q;
    logic                   carry_q;
    logic                   vld_q;

    if (k == 0) begin : g_head
      assign a_s    = a_i;
      assign b_s    = sub_i ? ~b_i : b_i;
      assign c_s    = sub_i | carry_i;
      assign v_s    = valid_i;
      assign sum_nx = res[CHUNK-1:0];
    end else begin : g_body
      assign a_s    = g_stage[k-1].g_fwd.a_q;
      assign b_s    = g_stage[k-1].g_fwd.b_q;
      assign c_s    = g_stage[k-1].carry_q;
      assign v_s    = g_stage[k-1].vld_q;
      assign sum_nx = {res[CHUNK-1:0], g_stage[k-1].sum_q};
    end

    assign res = bk_add(a_s[CHUNK-1:0], b_s[CHUNK-1:0], c_s);

    // Stage valid, accumulated result slices and slice carry-out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q   <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        vld_q   <= v_s;
        carry_q <= res[CHUNK];
        sum_q   <= sum_nx;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IW-CHUNK-1:0] a_q;
      logic [IW-CHUNK-1:0] b_q;

      // Forward the operand slices not yet added.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_s[IW-1:CHUNK];
          b_q <= b_s[IW-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // Signed overflow: carry into the MSB (recovered as sum^a^b) xor carry out.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= res[CHUNK] ^ (res[CHUNK-1] ^ a_s[CHUNK-1] ^ b_s[CHUNK-1]);
        end
      end
    end
  end

  assign valid_o    = g_stage[STAGES-1].vld_q;
  assign sum_o      = g_stage[STAGES-1].sum_q;
  assign carry_o    = g_stage[STAGES-1].carry_q;
  assign overflow_o = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_brent_kung_adder_pipe.sv
// tb_brent_kung_adder_pipe
// Scoreboard bench: stimulus pushes expected results into a queue, and a
// negedge monitor pops and compares whenever the DUT emits a beat.
module tb_brent_kung_adder_pipe;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int STAGES = WIDTH / CHUNK;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    int               acc;
    bit               lat_chk;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             sweep_rst_n = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             carry_i = 1'b0;
  logic             sub_i = 1'b0;
  logic             valid_o;
  logic             ready_i = 1'b0;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             overflow_o;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  int               run_len = 0;
  int               max_run = 0;
  int               stall_cycles = 0;
  bit               hold_valid = 0;
  logic [WIDTH-1:0] hold_sum;
  logic             hold_carry;
  logic             hold_ovf;

  brent_kung_adder_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .carry_i(carry_i), .sub_i(sub_i),
    .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o),
    .carry_o(carry_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.carry = c; e.ovf = o; e.acc = 0; e.lat_chk = 0;
    return e;
  endfunction

  // Reference model: plain wide addition of A, B' and the effective carry-in.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    logic             ci;
    bb   = sub ? ~b : b;
    ci   = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
    return mk(full[WIDTH-1:0], full[WIDTH],
              (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]));
  endfunction

  // Present one beat, hold it until accepted, then queue its expected result.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic sub, input exp_t e, input bit lat);
    int guard;
    exp_t x;
    @(posedge clk);
    #1;
    valid_i = 1'b1; a_i = a; b_i = b; carry_i = cin; sub_i = sub;
    guard = 0;
    @(negedge clk);
    while (!ready_o && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!ready_o) checkOutput("accept_timeout", 64'(ready_o), 64'd1);
    x = e;
    x.acc = cyc + 1;
    x.lat_chk = lat;
    exp_q.push_back(x);
  endtask

  task automatic endStream();
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    checkOutput("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: handshake rule, stall stability, and in-order scoreboard compare.
  always @(negedge clk) begin
    if (!rst_ni) begin
      hold_valid = 0;
      run_len = 0;
    end else begin
      checkOutput("ready_o_rule", 64'(ready_o), 64'(!valid_o || ready_i));
      if (hold_valid) begin
        checkOutput("hold_valid", 64'(valid_o), 64'd1);
        checkOutput("hold_sum", 64'(sum_o), 64'(hold_sum));
        checkOutput("hold_carry", 64'(carry_o), 64'(hold_carry));
        checkOutput("hold_ovf", 64'(overflow_o), 64'(hold_ovf));
      end
      hold_valid = valid_o && !ready_i;
      hold_sum = sum_o; hold_carry = carry_o; hold_ovf = overflow_o;
      if (hold_valid) stall_cycles++;
      if (valid_o) run_len++; else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 64'(valid_o), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("sum", 64'(sum_o), 64'(e.sum));
          checkOutput("carry", 64'(carry_o), 64'(e.carry));
          checkOutput("overflow", 64'(overflow_o), 64'(e.ovf));
          if (e.lat_chk) checkOutput("latency", 64'(cyc - e.acc + 1), 64'(STAGES));
        end
      end
    end
  end

  // Parameter sweep: independent instances with random beats and a local model.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SW = (g == 0) ? 8 : ((g == 1) ? 16 : 64);
    localparam int SC = (g == 0) ? 8 : ((g == 1) ? 4 : 16);
    localparam int ST = SW / SC;

    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_vout;
    logic          s_cin = 1'b0;
    logic          s_sub = 1'b0;
    logic          s_cout;
    logic          s_ovf;
    logic [SW-1:0] s_a = '0;
    logic [SW-1:0] s_b = '0;
    logic [SW-1:0] s_sum;
    logic [SW+1:0] s_q[$];
    int            s_acc[$];
    int            pops = 0;
    bit            done = 0;

    brent_kung_adder_pipe #(.WIDTH(SW), .CHUNK(SC)) u_sweep (
      .clk_i(clk), .rst_ni(sweep_rst_n), .valid_i(s_valid), .ready_o(s_ready),
      .a_i(s_a), .b_i(s_b), .carry_i(s_cin), .sub_i(s_sub),
      .valid_o(s_vout), .ready_i(1'b1), .sum_o(s_sum),
      .carry_o(s_cout), .overflow_o(s_ovf)
    );

    initial begin
      logic [SW-1:0] bb;
      logic [SW:0]   full;
      int            guard;
      wait (sweep_rst_n);
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        if (i == 0) begin
          s_a = '1; s_b = '0; s_cin = 1'b1; s_sub = 1'b0;
        end else begin
          s_a   = SW'({$urandom, $urandom});
          s_b   = SW'({$urandom, $urandom});
          s_cin = 1'($urandom_range(0, 1));
          s_sub = 1'(i % 2);
        end
        bb   = s_sub ? ~s_b : s_b;
        full = {1'b0, s_a} + {1'b0, bb} + (SW+1)'(s_sub | s_cin);
        @(negedge clk);
        checkOutput($sformatf("sweep%0d_ready", g), 64'(s_ready), 64'd1);
        s_q.push_back({full[SW], (s_a[SW-1] == bb[SW-1]) && (full[SW-1] != s_a[SW-1]), full[SW-1:0]});
        s_acc.push_back(cyc + 1);
      end
      @(posedge clk);
      #1 s_valid = 1'b0;
      guard = 0;
      while (pops < 12 && guard < 100) begin
        guard++;
        @(negedge clk);
      end
      checkOutput($sformatf("sweep%0d_beats", g), 64'(pops), 64'd12);
      done = 1;
    end

    always @(negedge clk) begin
      if (sweep_rst_n && s_vout) begin
        if (s_q.size() == 0) begin
          checkOutput($sformatf("sweep%0d_unexpected", g), 64'(s_vout), 64'd0);
        end else begin
          logic [SW+1:0] e;
          int            acc;
          e   = s_q.pop_front();
          acc = s_acc.pop_front();
          checkOutput($sformatf("sweep%0d_sum", g), 64'(s_sum), 64'(e[SW-1:0]));
          checkOutput($sformatf("sweep%0d_carry", g), 64'(s_cout), 64'(e[SW+1]));
          checkOutput($sformatf("sweep%0d_ovf", g), 64'(s_ovf), 64'(e[SW]));
          checkOutput($sformatf("sweep%0d_latency", g), 64'(cyc - acc + 1), 64'(ST));
          pops++;
        end
      end
    end
  end

  initial begin
    int vcount;
    int guard;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_valid_o", 64'(valid_o), 64'd0);
    checkOutput("reset_sum_o", 64'(sum_o), 64'd0);
    checkOutput("reset_carry_o", 64'(carry_o), 64'd0);
    checkOutput("reset_overflow_o", 64'(overflow_o), 64'd0);
    checkOutput("reset_ready_o", 64'(ready_o), 64'd1);
    rst_ni = 1'b1;
    sweep_rst_n = 1'b1;
    ready_i = 1'b1;

    // Directed vectors, hand-computed results
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0), 1);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1), 1);
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0), 1);
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0), 1);
    applyStimulus(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, mk(32'h0000_0002, 1'b1, 1'b0), 1);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1), 1);
    applyStimulus(32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, mk(32'h2222_2221, 1'b0, 1'b0), 1);
    endStream();
    waitDrain();

    // Back-to-back stream of 16 beats with alternating mode
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, 1'(i % 2), model(ra, rb, rc, 1'(i % 2)), 1);
    end
    endStream();
    waitDrain();
    checkOutput("stream_run_length", 64'(max_run), 64'd16);

    // Back-pressure: 3-cycle ready_i drop in the middle of an 8-beat stream
    stall_cycles = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
          applyStimulus(ra, rb, rc, 1'(i % 2), model(ra, rb, rc, 1'(i % 2)), 0);
        end
        endStream();
      end
      begin
        repeat (6) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    waitDrain();
    checkOutput("stall_cycles", 64'(stall_cycles), 64'd3);

    // Asynchronous reset with beats still in flight
    for (int i = 0; i < 5; i++)
      applyStimulus(32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0, mk(32'h0000_0002, 1'b1, 1'b1), 0);
    @(posedge clk);
    #1 valid_i = 1'b0;
    #1 checkOutput("prereset_valid_o", 64'(valid_o), 64'd1);
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("async_valid_o", 64'(valid_o), 64'd0);
    checkOutput("async_sum_o", 64'(sum_o), 64'd0);
    checkOutput("async_carry_o", 64'(carry_o), 64'd0);
    checkOutput("async_overflow_o", 64'(overflow_o), 64'd0);
    exp_q.delete();
    ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ready_o", 64'(ready_o), 64'd1);
    vcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid_o) vcount++;
    end
    checkOutput("stale_beats", 64'(vcount), 64'd0);
    ready_i = 1'b1;

    // Wait for the sweep instances
    guard = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    checkOutput("sweep_done", 64'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
